// File: rtl/pipe_ctrl_pkg.sv
// Shared types and helpers for the OTTER pipeline hazard controller.
// Used by pipe_hazard_ctrl and pipe_fwd_unit.
package pipe_ctrl_pkg;

   typedef enum logic {
      RUN   = 1'b0,
      DWAIT = 1'b1
   } hz_state_t;

   typedef enum logic [1:0] {
      FWD_RF    = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10
   } fwd_sel_t;

   localparam logic [4:0] REG_X0 = 5'd0;

   // True when a producer writing rd feeds a source operand that is actually read.
   function automatic logic src_match(input logic [4:0] rd,
                                      input logic [4:0] rs,
                                      input logic       used);
      return (rd != REG_X0) && used && (rs == rd);
   endfunction

   function automatic logic raw_hit(input logic       wr,
                                    input logic [4:0] rd,
                                    input logic [4:0] rs1,
                                    input logic       rs1_used,
                                    input logic [4:0] rs2,
                                    input logic       rs2_used);
      return wr && (src_match(rd, rs1, rs1_used) || src_match(rd, rs2, rs2_used));
   endfunction

endpackage

// File: rtl/pipe_fwd_unit.sv
// Per-operand ALU forward select: EX/MEM result beats MEM/WB result, x0 never forwards.
module pipe_fwd_unit
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] mem_rd_i,
   input  logic       mem_reg_write_i,
   input  logic [4:0] wb_rd_i,
   input  logic       wb_reg_write_i,
   output logic [1:0] sel_o
);

   fwd_sel_t sel_s;

   // Youngest in-flight producer wins.
   always_comb begin
      sel_s = FWD_RF;
      if (rs_i == REG_X0) begin
         sel_s = FWD_RF;
      end else if (mem_reg_write_i && (mem_rd_i == rs_i)) begin
         sel_s = FWD_EXMEM;
      end else if (wb_reg_write_i && (wb_rd_i == rs_i)) begin
         sel_s = FWD_MEMWB;
      end else begin
         sel_s = FWD_RF;
      end
   end

   assign sel_o = sel_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for the 5-stage OTTER: enables, bubbles, forwarding, DMEM wait FSM.
// Optional macro PIPE_FORWARDING_EN enables operand forwarding; otherwise every RAW hazard stalls.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 64,
   parameter int CNT_W    = 32
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       de_rs1,
   input  logic [4:0]       de_rs2,
   input  logic             de_rs1_used,
   input  logic             de_rs2_used,
   input  logic [4:0]       ex_rd,
   input  logic             ex_regWrite,
   input  logic             ex_memRDEN2,
   input  logic [4:0]       mem_rd,
   input  logic             mem_regWrite,
   input  logic             mem_access,
   input  logic [4:0]       wb_rd,
   input  logic             wb_regWrite,
   input  logic             ex_redirect,
   input  logic             dmem_ready,
   output logic             pc_we,
   output logic             if_de_we,
   output logic             de_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_de_flush,
   output logic             de_ex_flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_count
);

   localparam int                WCNT_W   = $clog2(MAX_WAIT + 1);
   localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

   hz_state_t         state_q;
   logic [WCNT_W-1:0] wait_cnt_q;
   logic [WCNT_W-1:0] wait_cnt_d;
   logic              mem_timeout_q;
   logic [CNT_W-1:0]  stall_cycles_q;
   logic [CNT_W-1:0]  redirect_count_q;

   logic              mem_wait_s;
   logic              ex_hit_s;
   logic              data_stall_s;
   logic [1:0]        fwd_a_calc_s;
   logic [1:0]        fwd_b_calc_s;
   logic [1:0]        fwd_a_s;
   logic [1:0]        fwd_b_s;

   assign mem_wait_s = mem_access & ~dmem_ready;
   assign ex_hit_s   = raw_hit(ex_regWrite, ex_rd, de_rs1, de_rs1_used, de_rs2, de_rs2_used);

   pipe_fwd_unit u_fwd_a (
      .rs_i            (de_rs1),
      .mem_rd_i        (mem_rd),
      .mem_reg_write_i (mem_regWrite),
      .wb_rd_i         (wb_rd),
      .wb_reg_write_i  (wb_regWrite),
      .sel_o           (fwd_a_calc_s)
   );

   pipe_fwd_unit u_fwd_b (
      .rs_i            (de_rs2),
      .mem_rd_i        (mem_rd),
      .mem_reg_write_i (mem_regWrite),
      .wb_rd_i         (wb_rd),
      .wb_reg_write_i  (wb_regWrite),
      .sel_o           (fwd_b_calc_s)
   );

`ifdef PIPE_FORWARDING_EN
   // Only a load result is too late to forward into EX.
   assign data_stall_s = ex_memRDEN2 & ex_hit_s;
   assign fwd_a_s      = fwd_a_calc_s;
   assign fwd_b_s      = fwd_b_calc_s;
`else
   logic       mem_hit_s;
   logic       wb_hit_s;
   logic [4:0] unused_fwd_s;

   // Without forwarding the consumer waits until no producer in EX, MEM or WB remains.
   assign mem_hit_s    = raw_hit(mem_regWrite, mem_rd, de_rs1, de_rs1_used, de_rs2, de_rs2_used);
   assign wb_hit_s     = raw_hit(wb_regWrite, wb_rd, de_rs1, de_rs1_used, de_rs2, de_rs2_used);
   assign data_stall_s = ex_hit_s | mem_hit_s | wb_hit_s;
   assign fwd_a_s      = FWD_RF;
   assign fwd_b_s      = FWD_RF;
   assign unused_fwd_s = {ex_memRDEN2, fwd_a_calc_s, fwd_b_calc_s};
`endif

   // Stage enables and bubbles, highest priority first: reset, memory wait, redirect, data hazard.
   always_comb begin
      pc_we       = 1'b1;
      if_de_we    = 1'b1;
      de_ex_we    = 1'b1;
      ex_mem_we   = 1'b1;
      mem_wb_we   = 1'b1;
      if_de_flush = 1'b0;
      de_ex_flush = 1'b0;
      fwd_a_sel   = fwd_a_s;
      fwd_b_sel   = fwd_b_s;
      if (RST) begin
         pc_we       = 1'b0;
         if_de_we    = 1'b0;
         de_ex_we    = 1'b0;
         ex_mem_we   = 1'b0;
         mem_wb_we   = 1'b0;
         if_de_flush = 1'b1;
         de_ex_flush = 1'b1;
         fwd_a_sel   = FWD_RF;
         fwd_b_sel   = FWD_RF;
      end else if (mem_wait_s) begin
         pc_we       = 1'b0;
         if_de_we    = 1'b0;
         de_ex_we    = 1'b0;
         ex_mem_we   = 1'b0;
         mem_wb_we   = 1'b0;
      end else if (ex_redirect) begin
         // The stalled consumer, if any, is squashed here, so no hazard stall is needed.
         if_de_flush = 1'b1;
         de_ex_flush = 1'b1;
      end else if (data_stall_s) begin
         pc_we       = 1'b0;
         if_de_we    = 1'b0;
         de_ex_flush = 1'b1;
      end else begin
         pc_we       = 1'b1;
      end
   end

   assign wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : (wait_cnt_q + WCNT_W'(1));

   // Data-memory wait FSM with saturating wait counter and sticky timeout flag.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         case (state_q)
            RUN: begin
               if (mem_wait_s) begin
                  state_q    <= DWAIT;
                  wait_cnt_q <= wait_cnt_d;
                  if (wait_cnt_d == WAIT_MAX) begin
                     mem_timeout_q <= 1'b1;
                  end
               end else begin
                  state_q    <= RUN;
                  wait_cnt_q <= '0;
               end
            end
            DWAIT: begin
               if (mem_wait_s) begin
                  state_q    <= DWAIT;
                  wait_cnt_q <= wait_cnt_d;
                  if (wait_cnt_d == WAIT_MAX) begin
                     mem_timeout_q <= 1'b1;
                  end
               end else begin
                  state_q    <= RUN;
                  wait_cnt_q <= '0;
               end
            end
            default: begin
               state_q    <= RUN;
               wait_cnt_q <= '0;
            end
         endcase
      end
   end

   // Performance counters; both wrap naturally at 2^CNT_W.
   always_ff @(posedge CLK) begin
      if (RST) begin
         stall_cycles_q   <= '0;
         redirect_count_q <= '0;
      end else begin
         if (!pc_we) begin
            stall_cycles_q <= stall_cycles_q + CNT_W'(1);
         end
         if (ex_redirect && !mem_wait_s) begin
            redirect_count_q <= redirect_count_q + CNT_W'(1);
         end
      end
   end

   assign mem_timeout    = mem_timeout_q;
   assign stall_cycles   = stall_cycles_q;
   assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a rule-level model.
module tb_pipe_hazard_ctrl;

   localparam int TB_MAX_WAIT = 4;

   logic        CLK;
   logic        RST;
   logic [4:0]  de_rs1, de_rs2, ex_rd, mem_rd, wb_rd;
   logic        de_rs1_used, de_rs2_used;
   logic        ex_regWrite, ex_memRDEN2, mem_regWrite, mem_access, wb_regWrite;
   logic        ex_redirect, dmem_ready;
   logic        pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we;
   logic        if_de_flush, de_ex_flush;
   logic [1:0]  fwd_a_sel, fwd_b_sel;
   logic        mem_timeout;
   logic [31:0] stall_cycles, redirect_count;

   int checks   = 0;
   int failures = 0;

   // model state
   int          m_waitrun = 0;
   bit          m_tmo     = 1'b0;
   logic [31:0] m_stall   = 32'd0;
   logic [31:0] m_redir   = 32'd0;
   logic [4:0]  e_en;
   logic [1:0]  e_fl;
   logic [1:0]  e_fa, e_fb;

   pipe_hazard_ctrl #(.MAX_WAIT(TB_MAX_WAIT), .CNT_W(32)) dut (
      .CLK(CLK), .RST(RST),
      .de_rs1(de_rs1), .de_rs2(de_rs2),
      .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
      .ex_rd(ex_rd), .ex_regWrite(ex_regWrite), .ex_memRDEN2(ex_memRDEN2),
      .mem_rd(mem_rd), .mem_regWrite(mem_regWrite), .mem_access(mem_access),
      .wb_rd(wb_rd), .wb_regWrite(wb_regWrite),
      .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
      .pc_we(pc_we), .if_de_we(if_de_we), .de_ex_we(de_ex_we),
      .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
      .if_de_flush(if_de_flush), .de_ex_flush(de_ex_flush),
      .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .mem_timeout(mem_timeout),
      .stall_cycles(stall_cycles), .redirect_count(redirect_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Does a producer (wr, rd) feed an operand the DE instruction reads?
   function automatic bit feeds(input logic wr, input logic [4:0] rd);
      if (!wr || rd == 5'd0) return 1'b0;
      return (de_rs1_used && de_rs1 == rd) || (de_rs2_used && de_rs2 == rd);
   endfunction

   function automatic logic [1:0] fwd_for(input logic [4:0] rs);
`ifdef PIPE_FORWARDING_EN
      if (RST || rs == 5'd0) return 2'd0;
      if (mem_regWrite && mem_rd == rs) return 2'd1;
      if (wb_regWrite && wb_rd == rs) return 2'd2;
      return 2'd0;
`else
      return (rs === 5'bxxxxx) ? 2'd3 : 2'd0;
`endif
   endfunction

   task automatic model_expect();
      bit waiting;
      bit hazard;
      waiting = mem_access && !dmem_ready;
`ifdef PIPE_FORWARDING_EN
      hazard = ex_memRDEN2 && feeds(ex_regWrite, ex_rd);
`else
      hazard = feeds(ex_regWrite, ex_rd) || feeds(mem_regWrite, mem_rd) || feeds(wb_regWrite, wb_rd);
`endif
      if (RST)              begin e_en = 5'b00000; e_fl = 2'b11; end
      else if (waiting)     begin e_en = 5'b00000; e_fl = 2'b00; end
      else if (ex_redirect) begin e_en = 5'b11111; e_fl = 2'b11; end
      else if (hazard)      begin e_en = 5'b00111; e_fl = 2'b01; end
      else                  begin e_en = 5'b11111; e_fl = 2'b00; end
      e_fa = fwd_for(de_rs1);
      e_fb = fwd_for(de_rs2);
   endtask

   task automatic compare_cycle();
      model_expect();
      chk("enables", {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we}, e_en);
      chk("flushes", {if_de_flush, de_ex_flush}, e_fl);
      chk("fwd_a_sel", fwd_a_sel, e_fa);
      chk("fwd_b_sel", fwd_b_sel, e_fb);
      chk("mem_timeout", mem_timeout, m_tmo);
      chk("stall_cycles", stall_cycles, m_stall);
      chk("redirect_count", redirect_count, m_redir);
   endtask

   task automatic model_update();
      bit waiting;
      waiting = mem_access && !dmem_ready;
      if (RST) begin
         m_waitrun = 0;
         m_tmo     = 1'b0;
         m_stall   = 32'd0;
         m_redir   = 32'd0;
      end else begin
         if (!e_en[4]) m_stall = m_stall + 32'd1;
         if (ex_redirect && !waiting) m_redir = m_redir + 32'd1;
         if (waiting) m_waitrun = (m_waitrun >= TB_MAX_WAIT) ? TB_MAX_WAIT : m_waitrun + 1;
         else m_waitrun = 0;
         if (m_waitrun == TB_MAX_WAIT) m_tmo = 1'b1;
      end
   endtask

   task automatic idle();
      RST = 1'b0;
      de_rs1 = 5'd0; de_rs2 = 5'd0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
      ex_rd = 5'd0; ex_regWrite = 1'b0; ex_memRDEN2 = 1'b0;
      mem_rd = 5'd0; mem_regWrite = 1'b0; mem_access = 1'b0;
      wb_rd = 5'd0; wb_regWrite = 1'b0;
      ex_redirect = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic settle();
      #2;
      compare_cycle();
   endtask

   task automatic advance();
      model_update();
      @(negedge CLK);
   endtask

   task automatic load_use_r5();
      ex_memRDEN2 = 1'b1; ex_regWrite = 1'b1; ex_rd = 5'd5;
      de_rs1 = 5'd5; de_rs1_used = 1'b1;
   endtask

   int burst;

   initial begin
      idle();
      RST = 1'b1;
      @(negedge CLK);

      // reset
      settle();
      chk("lit_rst_pc_we", pc_we, 1'b0);
      chk("lit_rst_flush", {if_de_flush, de_ex_flush}, 2'b11);
      chk("lit_rst_stall", stall_cycles, 32'd0);
      advance();
      idle(); settle();
      chk("lit_run_en", {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we}, 5'b11111);
      advance();

      // load-use: one bubble
      idle(); load_use_r5(); settle();
      chk("lit_lu_en", {pc_we, if_de_we, de_ex_we}, 3'b001);
      chk("lit_lu_flush", de_ex_flush, 1'b1);
      advance();
      idle(); settle();
      chk("lit_lu_release", pc_we, 1'b1);
      chk("lit_lu_stall1", stall_cycles, 32'd1);
      advance();

      // forwarding priority (rs2 not marked used so no-forward build does not stall)
      idle(); mem_rd = 5'd7; mem_regWrite = 1'b1; wb_rd = 5'd7; wb_regWrite = 1'b1; de_rs2 = 5'd7;
      settle();
`ifdef PIPE_FORWARDING_EN
      chk("lit_fwd_mem", fwd_b_sel, 2'b01);
`else
      chk("lit_fwd_tied", fwd_b_sel, 2'b00);
`endif
      advance();
      mem_regWrite = 1'b0; settle();
`ifdef PIPE_FORWARDING_EN
      chk("lit_fwd_wb", fwd_b_sel, 2'b10);
`else
      chk("lit_fwd_tied2", fwd_b_sel, 2'b00);
`endif
      advance();
      mem_regWrite = 1'b1; de_rs2 = 5'd0; settle();
      chk("lit_fwd_x0", fwd_b_sel, 2'b00);
      advance();

      // redirect overrides load-use
      idle(); load_use_r5(); ex_redirect = 1'b1; settle();
      chk("lit_redir_pc_we", pc_we, 1'b1);
      chk("lit_redir_flush", {if_de_flush, de_ex_flush}, 2'b11);
      advance();
      idle(); settle();
      chk("lit_redir_cnt", redirect_count, 32'd1);
      advance();

      // memory wait for 3 cycles; a redirect during the freeze is not counted
      for (int i = 0; i < 3; i++) begin
         idle(); mem_access = 1'b1; dmem_ready = 1'b0; ex_redirect = 1'b1; settle();
         chk("lit_wait_en", {pc_we, mem_wb_we, if_de_flush}, 3'b000);
         advance();
      end
      idle(); mem_access = 1'b1; settle();
      chk("lit_wait_done_en", {pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we}, 5'b11111);
      chk("lit_wait_stall4", stall_cycles, 32'd4);
      chk("lit_wait_redir", redirect_count, 32'd1);
      chk("lit_wait_no_tmo", mem_timeout, 1'b0);
      advance();

      // timeout after MAX_WAIT wait cycles, sticky until reset
      for (int i = 0; i < TB_MAX_WAIT; i++) begin
         idle(); mem_access = 1'b1; dmem_ready = 1'b0; settle();
         chk("lit_tmo_pending", mem_timeout, 1'b0);
         advance();
      end
      idle(); mem_access = 1'b1; settle();
      chk("lit_tmo_set", mem_timeout, 1'b1);
      advance();
      idle(); settle();
      chk("lit_tmo_sticky", mem_timeout, 1'b1);
      advance();
      idle(); RST = 1'b1; settle();
      advance();
      idle(); settle();
      chk("lit_tmo_cleared", mem_timeout, 1'b0);
      chk("lit_cnt_cleared", {stall_cycles, redirect_count}, 64'd0);
      advance();

      // producer of x3 moving EX -> MEM -> WB
      idle(); ex_rd = 5'd3; ex_regWrite = 1'b1; de_rs1 = 5'd3; de_rs1_used = 1'b1; settle();
`ifdef PIPE_FORWARDING_EN
      chk("lit_raw_ex", pc_we, 1'b1);
`else
      chk("lit_raw_ex", pc_we, 1'b0);
`endif
      advance();
      idle(); mem_rd = 5'd3; mem_regWrite = 1'b1; de_rs1 = 5'd3; de_rs1_used = 1'b1; settle();
`ifdef PIPE_FORWARDING_EN
      chk("lit_raw_mem", {pc_we, fwd_a_sel}, 3'b101);
`else
      chk("lit_raw_mem", {pc_we, fwd_a_sel}, 3'b000);
`endif
      advance();
      idle(); wb_rd = 5'd3; wb_regWrite = 1'b1; de_rs1 = 5'd3; de_rs1_used = 1'b1; settle();
`ifdef PIPE_FORWARDING_EN
      chk("lit_raw_wb", {pc_we, fwd_a_sel}, 3'b110);
`else
      chk("lit_raw_wb", {pc_we, fwd_a_sel}, 3'b000);
`endif
      advance();
      idle(); de_rs1 = 5'd3; de_rs1_used = 1'b1; settle();
      chk("lit_raw_release", pc_we, 1'b1);
`ifdef PIPE_FORWARDING_EN
      chk("lit_raw_stalls", stall_cycles, 32'd0);
`else
      chk("lit_raw_stalls", stall_cycles, 32'd3);
`endif
      advance();

      // randomized traffic
      burst = 0;
      for (int n = 0; n < 3000; n++) begin
         RST          = ($urandom_range(0, 49) == 0);
         de_rs1       = 5'($urandom_range(0, 3));
         de_rs2       = 5'($urandom_range(0, 3));
         de_rs1_used  = 1'($urandom_range(0, 1));
         de_rs2_used  = 1'($urandom_range(0, 1));
         ex_rd        = 5'($urandom_range(0, 3));
         ex_regWrite  = 1'($urandom_range(0, 1));
         ex_memRDEN2  = 1'($urandom_range(0, 1));
         mem_rd       = 5'($urandom_range(0, 3));
         mem_regWrite = 1'($urandom_range(0, 1));
         wb_rd        = 5'($urandom_range(0, 3));
         wb_regWrite  = 1'($urandom_range(0, 1));
         ex_redirect  = ($urandom_range(0, 5) == 0);
         if (burst == 0 && $urandom_range(0, 79) == 0) burst = 6;
         if (burst > 0) begin
            mem_access = 1'b1;
            dmem_ready = 1'b0;
            burst--;
         end else begin
            mem_access = ($urandom_range(0, 2) == 0);
            dmem_ready = ($urandom_range(0, 2) != 0);
         end
         settle();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage pipelined OTTER (IF/DE/EX/MEM/WB).
- Consumes decoded control (regWrite, memRDEN2, memWE2, jump/branch redirect) and register indices carried down the pipe.
- Drives PC and pipeline-register write enables, bubble/flush controls and ALU operand forwarding selects.
- Owns the data-memory wait FSM, timeout detection and stall/flush performance counters.

Parameters:
- MAX_WAIT, 64: DWAIT cycles before mem_timeout asserts.
- CNT_W, 32: width of performance counters.

Ports:
- CLK  in  1  system clock, all state on rising edge
- RST  in  1  synchronous, active-high reset
- de_rs1, de_rs2  in  5  source regs of instruction in DE
- de_rs1_used, de_rs2_used  in  1  DE instruction actually reads rs1/rs2
- ex_rd  in  5  dest reg in EX
- ex_regWrite, ex_memRDEN2  in  1  EX-stage control
- mem_rd  in  5  dest reg in MEM
- mem_regWrite  in  1  MEM-stage control
- mem_access  in  1  MEM-stage instruction is a load or store (memRDEN2 or memWE2)
- wb_rd  in  5  dest reg in WB
- wb_regWrite  in  1  WB-stage control
- ex_redirect  in  1  taken branch, jal or jalr resolved in EX
- dmem_ready  in  1  data memory completes the current MEM access this cycle
- pc_we, if_de_we, de_ex_we, ex_mem_we, mem_wb_we  out  1  stage register enables
- if_de_flush, de_ex_flush  out  1  load NOP bubble into that register
- fwd_a_sel, fwd_b_sel  out  2  00 regfile, 01 EX/MEM result, 10 MEM/WB result
- mem_timeout  out  1  sticky, DWAIT exceeded MAX_WAIT
- stall_cycles, redirect_count  out  CNT_W  performance counters

Behaviour:
- FSM states (enum): RUN, DWAIT. Reset → RUN, wait_cnt=0, mem_timeout=0, both counters 0.
- While RST=1: all *_we=0, both flushes=1, fwd selects=00.
- A hazard match requires rd≠0, a matching rs, and the corresponding *_used bit set.
- Priority, highest first:
  1. Memory wait: mem_access & !dmem_ready.
     - All *_we=0 and flushes=0; pipeline frozen, so redirect and load-use are re-evaluated later.
     - RUN→DWAIT on the first such cycle; stay in DWAIT while the condition holds.
     - DWAIT→RUN on the cycle dmem_ready=1; that cycle behaves as RUN.
  2. Redirect: ex_redirect=1.
     - pc_we=1 (loads target); all stage we=1.
     - if_de_flush=1, de_ex_flush=1: two bubbles.
     - Overrides load-use, since the stalled instruction is squashed.
  3. Load-use: ex_memRDEN2 & ex_regWrite & match(ex_rd).
     - pc_we=0, if_de_we=0, de_ex_flush=1, later stages advance.
     - Exactly one bubble; the next cycle re-evaluates.
  4. Otherwise all *_we=1 and flushes=0.
- Forwarding (combinational, per operand):
  - EX/MEM match (mem_regWrite & mem_rd=rs) → 01.
  - Else MEM/WB match → 10.
  - Else 00.
  - MEM beats WB when both match; rs=x0 always gives 00.
- wait_cnt:
  - Increments each DWAIT cycle, saturates at MAX_WAIT, clears on return to RUN.
  - When wait_cnt reaches MAX_WAIT, mem_timeout sets and holds until RST.
- stall_cycles: +1 every cycle with pc_we=0 while RST=0.
- redirect_count: +1 per cycle with ex_redirect that is not frozen by a memory wait.
- Both counters wrap modulo 2^CNT_W.
- RST asserted mid-DWAIT: next state RUN, counters cleared, no pending action retained.

Optional Feature:
- Macro: PIPE_FORWARDING_EN.
- Defined: forwarding behaves as above.
- Undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - Any RAW match against EX, MEM or WB (with its regWrite) stalls as load-use does: pc_we=0, if_de_we=0, de_ex_flush=1.
  - The stall repeats each cycle until no match remains (up to 3 cycles).
  - Priority relative to redirect and memory wait is unchanged.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - enum typedef hz_state_t {RUN, DWAIT}
  - enum typedef fwd_sel_t {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10}
  - constant REG_X0=5'd0
- One natural sub-module: pipe_fwd_unit, the combinational per-operand forward select, instantiated twice (rs1, rs2).
- FSM, counters and enable/flush logic stay in pipe_hazard_ctrl.

Test Plan:
- Load-use: ex_memRDEN2=1, ex_regWrite=1, ex_rd=5, de_rs1=5, de_rs1_used=1 → one cycle pc_we=0, if_de_we=0, de_ex_flush=1; stall_cycles=1; next cycle (ex_memRDEN2=0) all we=1.
- Forwarding: mem_rd=7 and wb_rd=7, both regWrite, de_rs2=7 → fwd_b_sel=01; with mem_regWrite=0 → 10; with de_rs2=0 → 00.
- Redirect coincident with load-use: ex_redirect=1 plus a load-use match → pc_we=1, both flushes=1; redirect_count=1.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles, then 1 → all we=0 for 3 cycles in DWAIT, RUN on cycle 4 with all we=1; stall_cycles=3.
- Timeout: dmem_ready held 0 with MAX_WAIT=4 → mem_timeout=1 once wait_cnt reaches 4; stays 1 after dmem_ready=1; clears only on RST.
- PIPE_FORWARDING_EN undefined: ex_rd=3 with ex_regWrite, de_rs1=3 → three consecutive stall cycles as the producer moves EX→MEM→WB, then release; fwd selects stay 00.
